// File: rtl/mem_slave_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg: shared constants and types for the mem_slave block.
//   - FSM state encodings (also exported on the mem_state debug port)
//   - default LATENCY / ADDR_WIDTH
//   - latency down-counter width and its load helper
// ---------------------------------------------------------------------------
package mem_pkg;

  localparam int DATA_W           = 32;
  localparam int DEF_ADDR_WIDTH   = 10;
  localparam int DEF_LATENCY      = 4;
  localparam int CNT_W            = 4;
  localparam int DBG_CNT_W        = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  typedef logic [CNT_W-1:0] cnt_t;

  // The counter is loaded with LATENCY-1 on accept so that S_BUSY can leave
  // on a count of 1 and land the ack exactly LATENCY cycles after accept.
  function automatic cnt_t lat_load(input int lat);
    return cnt_t'(lat - 1);
  endfunction

endpackage

// File: rtl/mem_slave_if.sv
// ---------------------------------------------------------------------------
// mem_slave_if: request/response bus between the cache controller (master)
// and the memory slave.
//   cs_i   : request valid, held high across back-to-back requests
//   we_i   : 1 = write, 0 = read
//   addr_i : byte address (bits [1:0] ignored by the slave)
//   data_i : write data
//   data_o : read data
//   ack_o  : one-cycle completion pulse
// ---------------------------------------------------------------------------
interface mem_slave_if;
  import mem_pkg::*;

  logic              cs_i;
  logic              we_i;
  logic [DATA_W-1:0] addr_i;
  logic [DATA_W-1:0] data_i;
  logic [DATA_W-1:0] data_o;
  logic              ack_o;

  modport master (
    output cs_i, we_i, addr_i, data_i,
    input  data_o, ack_o
  );

  modport slave (
    input  cs_i, we_i, addr_i, data_i,
    output data_o, ack_o
  );

endinterface

// File: rtl/mem_slave_array.sv
// ---------------------------------------------------------------------------
// mem_array: synchronous single-port RAM, 2^ADDR_WIDTH x 32-bit words.
//   clk      : clock
//   rst      : async active-low reset, clears only the read register
//   idx_i    : word index shared by read and write
//   we_i     : write enable, commits wdata_i at the clock edge
//   wdata_i  : write data
//   re_i     : read enable, loads rdata_o from idx_i at the clock edge
//   rdata_o  : registered read data, held between reads
// RAM contents are never reset.
// ---------------------------------------------------------------------------
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] idx_i,
  input  logic                  we_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic                  re_i,
  output logic [DATA_W-1:0]     rdata_o
);

  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_slave.sv
// ---------------------------------------------------------------------------
// mem_slave: fixed-latency memory slave for a cache controller.
//   clk       : clock, all state changes on the rising edge
//   rst       : async active-low reset (RAM contents survive)
//   bus       : mem_slave_if.slave request/response bus
//   mem_state : debug copy of the FSM state
//   rd_cnt    : completed reads, wraps at 16 bits
//   wr_cnt    : completed writes, wraps at 16 bits
//
// state  | meaning
// S_IDLE | waiting for cs_i; request latched on accept
// S_BUSY | latency countdown; cs_i low here aborts the request
// S_ACK  | ack_o high, read data valid, write commits at end of cycle
// ---------------------------------------------------------------------------
module mem_slave
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LATENCY    = DEF_LATENCY
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_slave_if.slave           bus,
  output logic [1:0]           mem_state,
  output logic [DBG_CNT_W-1:0] rd_cnt,
  output logic [DBG_CNT_W-1:0] wr_cnt
);

  logic [1:0]            state_q,  state_d;
  cnt_t                  cnt_q,    cnt_d;
  logic                  we_q,     we_d;
  logic [ADDR_WIDTH-1:0] idx_q,    idx_d;
  logic [DATA_W-1:0]     wdata_q,  wdata_d;
  logic                  ack_q,    ack_d;
  logic [DBG_CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [DBG_CNT_W-1:0]  wr_cnt_q, wr_cnt_d;

  logic                  ram_we;
  logic                  ram_re;
  logic [DATA_W-1:0]     ram_rdata;

  // Upper address bits wrap silently and the byte offset is ignored.
  logic unused_addr;
  assign unused_addr = ^{bus.addr_i[DATA_W-1:ADDR_WIDTH+2], bus.addr_i[1:0]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cs_i) begin
          we_d    = bus.we_i;
          idx_d   = bus.addr_i[ADDR_WIDTH+1:2];
          wdata_d = bus.data_i;
          cnt_d   = lat_load(LATENCY);
          state_d = (LATENCY == 1) ? S_ACK : S_BUSY;
        end
      end
      S_BUSY: begin
        if (!bus.cs_i) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
          if (cnt_q == cnt_t'(1)) begin
            state_d = S_ACK;
          end
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        if (we_q) begin
          wr_cnt_d = wr_cnt_q + DBG_CNT_W'(1);
        end else begin
          rd_cnt_d = rd_cnt_q + DBG_CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ack_d = (state_d == S_ACK);
  end

  // The RAM read is launched on the edge that enters S_ACK so its registered
  // output lands in the ack cycle. idx_d/we_d carry the live request when
  // LATENCY=1 (accept and ack-entry on the same edge) and the latched one
  // otherwise. Writes use idx_d too, which equals idx_q while in S_ACK.
  assign ram_re = ack_d && !we_d;
  assign ram_we = (state_q == S_ACK) && we_q;

  mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .idx_i   (idx_d),
    .we_i    (ram_we),
    .wdata_i (wdata_q),
    .re_i    (ram_re),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      ack_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      ack_q    <= ack_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign bus.ack_o  = ack_q;
  assign bus.data_o = ram_rdata;
  assign mem_state  = state_q;
  assign rd_cnt     = rd_cnt_q;
  assign wr_cnt     = wr_cnt_q;

endmodule

// File: tb/tb_mem_slave.sv
`timescale 1ns/1ps
module tb_mem_slave;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  mem_slave_if bus4 ();
  mem_slave_if bus1 ();

  logic        cs_d   [2];
  logic        we_d   [2];
  logic [31:0] addr_d [2];
  logic [31:0] data_d [2];

  assign bus4.cs_i   = cs_d[0];
  assign bus4.we_i   = we_d[0];
  assign bus4.addr_i = addr_d[0];
  assign bus4.data_i = data_d[0];
  assign bus1.cs_i   = cs_d[1];
  assign bus1.we_i   = we_d[1];
  assign bus1.addr_i = addr_d[1];
  assign bus1.data_i = data_d[1];

  logic [1:0]  st4, st1;
  logic [15:0] rd4, wr4, rd1, wr1;

  mem_slave #(.ADDR_WIDTH(10), .LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst_n), .bus(bus4), .mem_state(st4), .rd_cnt(rd4), .wr_cnt(wr4)
  );

  mem_slave #(.ADDR_WIDTH(10), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst_n), .bus(bus1), .mem_state(st1), .rd_cnt(rd1), .wr_cnt(wr1)
  );

  typedef struct {
    logic        is_rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb4[$];
  exp_t sb1[$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } vec_t;

  localparam int NV = 13;
  vec_t vt [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic mon_ack(input int w, input logic [31:0] dout);
    exp_t e;
    logic empty;
    empty = (w == 0) ? (sb4.size() == 0) : (sb1.size() == 0);
    total++;
    if (empty) begin
      bad++;
      $display("FAIL unexpected_ack dut%0d: got ack at cyc %0d want none", w, cyc);
    end else begin
      if (w == 0) e = sb4.pop_front();
      else        e = sb1.pop_front();
      if (cyc != e.cyc) begin
        bad++;
        $display("FAIL ack_cycle dut%0d: got %0d want %0d", w, cyc, e.cyc);
      end
      if (e.is_rd) chk($sformatf("rd_data dut%0d", w), dout, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus4.ack_o === 1'b1) mon_ack(0, bus4.data_o);
      if (bus1.ack_o === 1'b1) mon_ack(1, bus1.data_o);
    end
  end

  // One request; cs stays high until the ack is seen, inputs optionally
  // scrambled while the slave is busy.
  task automatic req(input int w, input logic we, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] exp_rd, input bit scramble);
    exp_t e;
    bit   got;
    logic a;
    @(negedge clk);
    cs_d[w]   = 1'b1;
    we_d[w]   = we;
    addr_d[w] = addr;
    data_d[w] = wd;
    e.is_rd = !we;
    e.data  = exp_rd;
    e.cyc   = cyc + ((w == 0) ? 4 : 1);
    if (w == 0) sb4.push_back(e);
    else        sb1.push_back(e);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      a = (w == 0) ? bus4.ack_o : bus1.ack_o;
      if (a === 1'b1) begin
        got = 1'b1;
      end else if (scramble) begin
        we_d[w]   = ($urandom() % 2) == 1;
        addr_d[w] = $urandom();
        data_d[w] = $urandom();
      end
    end
    cs_d[w] = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL ack_timeout dut%0d: got no ack want ack by cyc %0d", w, e.cyc);
    end
  endtask

  int          mrd, mwr;
  logic [31:0] last_rd;
  int          t0;
  bit          got;

  initial begin
    vt[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
    vt[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
    vt[2]  = '{1'b1, 32'h0000_0000, 32'h0000_0001, 32'h0};
    vt[3]  = '{1'b1, 32'h0000_0004, 32'h0000_0002, 32'h0};
    vt[4]  = '{1'b1, 32'h0000_0008, 32'h0000_0003, 32'h0};
    vt[5]  = '{1'b1, 32'h0000_000C, 32'h0000_0004, 32'h0};
    vt[6]  = '{1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 32'h0};
    vt[7]  = '{1'b1, 32'h0000_0024, 32'h0BAD_F00D, 32'h0};
    vt[8]  = '{1'b0, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF};
    vt[9]  = '{1'b0, 32'h0000_1010, 32'h0,         32'hDEAD_BEEF};
    vt[10] = '{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 32'h0};
    vt[11] = '{1'b0, 32'h0000_0FFC, 32'h0,         32'hCAFE_F00D};
    vt[12] = '{1'b0, 32'h0000_0020, 32'h0,         32'hA5A5_A5A5};

    for (int w = 0; w < 2; w++) begin
      cs_d[w] = 1'b0; we_d[w] = 1'b0; addr_d[w] = '0; data_d[w] = '0;
    end
    rst_n = 1'b0;
    mrd = 0; mwr = 0; last_rd = '0;

    repeat (2) @(negedge clk);
    chk("reset ack4",   {31'd0, bus4.ack_o}, 32'd0);
    chk("reset data4",  bus4.data_o, 32'd0);
    chk("reset state4", {30'd0, st4}, {30'd0, S_IDLE});
    chk("reset rd4",    {16'd0, rd4}, 32'd0);
    chk("reset wr4",    {16'd0, wr4}, 32'd0);
    chk("reset ack1",   {31'd0, bus1.ack_o}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // table-driven single requests on the LATENCY=4 instance
    for (int i = 0; i < NV; i++) begin
      req(0, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].rdata, 1'b1);
      if (vt[i].we) mwr++;
      else begin mrd++; last_rd = vt[i].rdata; end
      @(negedge clk);
      chk($sformatf("wr_cnt v%0d", i), {16'd0, wr4}, 32'(mwr));
      chk($sformatf("rd_cnt v%0d", i), {16'd0, rd4}, 32'(mrd));
      chk($sformatf("data_o hold v%0d", i), bus4.data_o, last_rd);
      chk($sformatf("idle v%0d", i), {30'd0, st4}, {30'd0, S_IDLE});
    end

    // burst: cs held high, next address presented in each ack cycle
    @(negedge clk);
    t0 = cyc;
    cs_d[0] = 1'b1; we_d[0] = 1'b0; addr_d[0] = 32'h0;
    sb4.push_back('{1'b1, 32'd1, t0 + 4});
    for (int b = 0; b < 4; b++) begin
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        if (bus4.ack_o === 1'b1) got = 1'b1;
      end
      if (!got) begin
        total++; bad++;
        $display("FAIL burst_timeout: got no ack want ack %0d", b);
      end
      if (b < 3) begin
        addr_d[0] = 32'((b + 1) * 4);
        sb4.push_back('{1'b1, 32'(b + 2), t0 + 5 * (b + 1) + 4});
      end else begin
        cs_d[0] = 1'b0;
      end
    end
    mrd += 4; last_rd = 32'd4;
    @(negedge clk);
    chk("burst rd_cnt", {16'd0, rd4}, 32'(mrd));
    chk("burst data_o", bus4.data_o, last_rd);

    // abort: cs dropped in cycle 2 of a write
    @(negedge clk);
    cs_d[0] = 1'b1; we_d[0] = 1'b1; addr_d[0] = 32'h20; data_d[0] = 32'h1234_5678;
    @(negedge clk);
    @(negedge clk);
    cs_d[0] = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort wr_cnt", {16'd0, wr4}, 32'(mwr));
    chk("abort state",  {30'd0, st4}, {30'd0, S_IDLE});
    req(0, 1'b0, 32'h20, 32'h0, 32'hA5A5_A5A5, 1'b0);
    mrd++; last_rd = 32'hA5A5_A5A5;
    @(negedge clk);
    chk("abort rd_cnt", {16'd0, rd4}, 32'(mrd));

    // reset in cycle 3 of a write to 0x24
    @(negedge clk);
    cs_d[0] = 1'b1; we_d[0] = 1'b1; addr_d[0] = 32'h24; data_d[0] = 32'hFFFF_0000;
    repeat (3) @(negedge clk);
    chk("pre-reset state", {30'd0, st4}, {30'd0, S_BUSY});
    rst_n = 1'b0;
    #1;
    chk("midrst ack",   {31'd0, bus4.ack_o}, 32'd0);
    chk("midrst data",  bus4.data_o, 32'd0);
    chk("midrst state", {30'd0, st4}, {30'd0, S_IDLE});
    chk("midrst rd",    {16'd0, rd4}, 32'd0);
    chk("midrst wr",    {16'd0, wr4}, 32'd0);
    cs_d[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mrd = 0; mwr = 0;
    repeat (4) @(negedge clk);
    chk("post-reset wr", {16'd0, wr4}, 32'd0);
    req(0, 1'b0, 32'h24, 32'h0, 32'h0BAD_F00D, 1'b0);
    mrd++;
    @(negedge clk);
    chk("post-reset rd_cnt", {16'd0, rd4}, 32'(mrd));
    chk("post-reset data",   bus4.data_o, 32'h0BAD_F00D);

    // LATENCY=1 with address wrap
    req(1, 1'b1, 32'h0000_1000, 32'h55, 32'h0, 1'b1);
    @(negedge clk);
    chk("lat1 wr_cnt", {16'd0, wr1}, 32'd1);
    chk("lat1 data_o unchanged", bus1.data_o, 32'd0);
    req(1, 1'b0, 32'h0, 32'h0, 32'h55, 1'b1);
    @(negedge clk);
    chk("lat1 rd_cnt", {16'd0, rd1}, 32'd1);
    chk("lat1 data_o", bus1.data_o, 32'h55);

    repeat (3) @(negedge clk);
    chk("sb4 drained", 32'(sb4.size()), 32'd0);
    chk("sb1 drained", 32'(sb1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish by 200000ns");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_slave.md
MEM_SLAVE -- requirements
Module: mem_slave

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, giving a RAM depth of 2^ADDR_WIDTH 32-bit words.
REQ-002 The block SHALL have parameter LATENCY, default 4, giving the cycles from request accept to ack; legal range is 1..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port cs_i, input, 1 bit: request valid; the cache controller holds it high across consecutive requests.
REQ-006 The block SHALL have port we_i, input, 1 bit: 1 means write, 0 means read.
REQ-007 The block SHALL have port addr_i, input, 32 bits: byte address; bits [1:0] are ignored.
REQ-008 The block SHALL have port data_i, input, 32 bits: write data.
REQ-009 The block SHALL have port data_o, output, 32 bits: read data.
REQ-010 The block SHALL have port ack_o, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port mem_state, output, 2 bits: debug copy of the FSM state.
REQ-012 The block SHALL have port rd_cnt, output, 16 bits: completed-read counter for debug.
REQ-013 The block SHALL have port wr_cnt, output, 16 bits: completed-write counter for debug.

Function
REQ-014 The FSM SHALL have three states: S_IDLE=0, S_BUSY=1, S_ACK=2.
REQ-015 In S_IDLE with cs_i=1 (cycle n), the block SHALL latch we_i, word index addr_i[ADDR_WIDTH+1:2] and data_i at the end of cycle n, and move to S_BUSY (or S_ACK if LATENCY=1).
REQ-016 The word index SHALL wrap modulo 2^ADDR_WIDTH; upper address bits are ignored and no error is flagged.
REQ-017 On accept, a down-counter SHALL load LATENCY-1; S_BUSY SHALL decrement it each cycle and enter S_ACK when it reaches 1.
REQ-018 ack_o SHALL be registered and high only in S_ACK, i.e. exactly cycle n+LATENCY, for exactly one cycle.
REQ-019 For a read, data_o SHALL hold the word at the latched index during the ack cycle, and SHALL hold that value until the next read ack.
REQ-020 For a write, the RAM SHALL commit the latched data at the end of the ack cycle; data_o SHALL be unchanged.
REQ-021 Inputs SHALL be ignored outside S_IDLE; address or data changes during S_BUSY or S_ACK have no effect.
REQ-022 From S_ACK the FSM SHALL always return to S_IDLE; with cs_i still high, the next request is accepted in the following cycle, so back-to-back requests take LATENCY+1 cycles each.
REQ-023 If cs_i is low in any S_BUSY cycle, the request SHALL be aborted: return to S_IDLE, no ack, no write, counters unchanged.
REQ-024 cs_i low in S_ACK SHALL NOT cancel the ack or the write.
REQ-025 rd_cnt and wr_cnt SHALL increment on each read or write ack, and SHALL wrap at 16 bits.
REQ-026 A read of a word written by an earlier completed write SHALL return the new data.

Reset
REQ-027 While rst=0, the block SHALL force state=S_IDLE, counter=0, ack_o=0, data_o=0, rd_cnt=0, wr_cnt=0 and clear the latched request, asynchronously.
REQ-028 A reset asserted mid-request SHALL abort it with no write committed and no ack.
REQ-029 Reset SHALL NOT clear RAM contents; the RAM is undefined until written, or initialised by the bench through a hierarchical preload.

Structure
REQ-030 A shared package mem_pkg SHALL hold the state encodings, the LATENCY and ADDR_WIDTH defaults, and the counter width (4 bits).
REQ-031 Sub-module mem_array SHALL implement the synchronous single-port RAM (word index, write enable, write data, read data); the FSM, counters and latches stay in mem_slave.
REQ-032 The RAM read SHALL be registered inside mem_array, timed so that data_o is valid in the ack cycle.

Verification
REQ-033 Reset, then write: cs=1, we=1, addr=0x10, data=0xDEADBEEF accepted at cycle 0 with LATENCY=4 -> ack_o high only in cycle 4; wr_cnt=1.
REQ-034 Read after write: read of addr 0x10 -> ack in cycle 4 of the request with data_o=0xDEADBEEF; rd_cnt=1.
REQ-035 Burst: cs held high for 4 reads at 0x0, 0x4, 0x8, 0xC (each address advanced in the ack cycle) -> acks at cycles 4, 9, 14, 19; data matches a preload of 1, 2, 3, 4.
REQ-036 Abort: write to 0x20, cs dropped in cycle 2 -> no ack, a later read of 0x20 returns the old value, wr_cnt unchanged.
REQ-037 Reset mid-op: rst=0 in cycle 3 of a write to 0x24 -> ack never asserted, word unchanged, all outputs 0.
REQ-038 Wrap and LATENCY=1: write 0x55 to addr 4<<ADDR_WIDTH... i.e. 0x1000 with ADDR_WIDTH=10, then read 0x0 -> ack 1 cycle after each accept, data_o=0x55.
